// File: rtl/piso_pkg.sv
// piso_pkg: shared state encoding and width helper for the PISO transmitter
package piso_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/piso_serial_tx_bit_counter.sv
// piso_bit_counter: bit position within a frame, wraps after WIDTH-1
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    en,
    output logic [cnt_w(WIDTH)-1:0] count,
    output logic                    last
);

    localparam int CW = cnt_w(WIDTH);

    logic [CW-1:0] r_count;

    assign count = r_count;
    assign last  = (r_count == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst || clear)
            r_count <= '0;
        else if (en)
            r_count <= last ? '0 : r_count + 1'b1;
    end

endmodule

// File: rtl/piso_serial_tx.sv
// piso_serial_tx: valid/ready loaded parallel-in serial-out transmitter
module piso_serial_tx
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             busy
);

    localparam int CW = cnt_w(WIDTH);

    if (WIDTH < 2) begin : g_width_check
        $error("piso_serial_tx: WIDTH must be at least 2");
    end

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_next;
    logic             r_ser_out;
    logic             r_ser_valid;
    logic             r_frame_start;
    logic             w_ser_next;
    logic             w_accept;
    logic             w_last;
    logic [CW-1:0]    w_count;

    piso_bit_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clear(w_accept),
        .en   (r_state == ST_SHIFT),
        .count(w_count),
        .last (w_last)
    );

    // Ready is decoded from registered state only, so it never loops back through load_valid
    assign load_ready = (r_state == ST_IDLE) ||
                        (r_state == ST_SHIFT && w_count == CW'(WIDTH - 1));
    assign w_accept   = load_valid && load_ready;

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = w_accept                         ? ST_SHIFT :
                 (r_state == ST_SHIFT && w_last)  ? ST_IDLE  : r_state;
    end

    // Shifting a full frame out leaves zeros behind, which keeps ser_out low when idle
    always_comb begin
        w_shift_next = w_accept              ? load_data :
                       (r_state == ST_SHIFT) ? (LSB_FIRST ? r_shift >> 1 : r_shift << 1) :
                                               r_shift;
        w_ser_next   = LSB_FIRST ? w_shift_next[0] : w_shift_next[WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift       <= '0;
            r_ser_out     <= 1'b0;
            r_ser_valid   <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_shift       <= w_shift_next;
            r_ser_out     <= w_ser_next;
            r_ser_valid   <= (w_next == ST_SHIFT);
            r_frame_start <= w_accept;
        end
    end

    assign ser_out     = r_ser_out;
    assign ser_valid   = r_ser_valid;
    assign frame_start = r_frame_start;
    assign busy        = r_ser_valid;

endmodule

// File: tb/tb_piso_serial_tx.sv
// tb_piso_serial_tx: directed checks of the PISO transmitter in both bit orders
module tb_piso_serial_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lv_l = 1'b0, lv_m = 1'b0;
    logic [7:0] ld_l = 8'h00, ld_m = 8'h00;
    logic       rdy_l, so_l, sv_l, fs_l, busy_l;
    logic       rdy_m, so_m, sv_m, fs_m, busy_m;
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0]  w;
    logic [15:0] s;

    always #5 clk = ~clk;

    piso_serial_tx #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_l (
        .clk(clk), .rst(rst), .load_valid(lv_l), .load_ready(rdy_l), .load_data(ld_l),
        .ser_out(so_l), .ser_valid(sv_l), .frame_start(fs_l), .busy(busy_l)
    );

    piso_serial_tx #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_m (
        .clk(clk), .rst(rst), .load_valid(lv_m), .load_ready(rdy_m), .load_data(ld_m),
        .ser_out(so_m), .ser_valid(sv_m), .frame_start(fs_m), .busy(busy_m)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".ser_out"}, so_l, 1'b0);
        chk({tag, ".ser_valid"}, sv_l, 1'b0);
        chk({tag, ".frame_start"}, fs_l, 1'b0);
        chk({tag, ".busy"}, busy_l, 1'b0);
        chk({tag, ".load_ready"}, rdy_l, 1'b1);
    endtask

    initial begin
        tick();
        tick();
        chk_idle("reset");
        chk("reset.m_ser_valid", sv_m, 1'b0);
        chk("reset.m_load_ready", rdy_m, 1'b1);
        rst = 1'b0;
        tick();

        // single frame A5, LSB first
        w = 8'hA5; ld_l = w; lv_l = 1'b1;
        tick();
        lv_l = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("a5.bit%0d", i), so_l, w[i]);
            chk($sformatf("a5.valid%0d", i), sv_l, 1'b1);
            chk($sformatf("a5.busy%0d", i), busy_l, 1'b1);
            chk($sformatf("a5.fs%0d", i), fs_l, i == 0);
            chk($sformatf("a5.rdy%0d", i), rdy_l, i == 7);
            tick();
        end
        chk_idle("a5.end");
        tick();

        // back-to-back A5 then 3C with load_valid held
        s = 16'h3CA5; ld_l = 8'hA5; lv_l = 1'b1;
        tick();
        ld_l = 8'h3C;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("b2b.bit%0d", i), so_l, s[i]);
            chk($sformatf("b2b.valid%0d", i), sv_l, 1'b1);
            chk($sformatf("b2b.fs%0d", i), fs_l, i == 0 || i == 8);
            chk($sformatf("b2b.rdy%0d", i), rdy_l, i == 7 || i == 15);
            if (i == 15) lv_l = 1'b0;
            tick();
        end
        chk_idle("b2b.end");

        // MSB first: A5 then 80
        w = 8'hA5; ld_m = w; lv_m = 1'b1;
        tick();
        lv_m = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("msb_a5.bit%0d", i), so_m, w[7-i]);
            chk($sformatf("msb_a5.fs%0d", i), fs_m, i == 0);
            tick();
        end
        chk("msb_a5.end_valid", sv_m, 1'b0);
        w = 8'h80; ld_m = w; lv_m = 1'b1;
        tick();
        lv_m = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("msb_80.bit%0d", i), so_m, w[7-i]);
            chk($sformatf("msb_80.valid%0d", i), sv_m, 1'b1);
            tick();
        end
        chk("msb_80.end_valid", sv_m, 1'b0);
        chk("msb_80.end_out", so_m, 1'b0);

        // load attempt while not ready is ignored
        ld_l = 8'h00; lv_l = 1'b1;
        tick();
        lv_l = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                chk("ign.rdy_at3", rdy_l, 1'b0);
                ld_l = 8'hFF; lv_l = 1'b1;
            end
            chk($sformatf("ign.bit%0d", i), so_l, 1'b0);
            chk($sformatf("ign.valid%0d", i), sv_l, 1'b1);
            tick();
            if (i == 3) begin
                lv_l = 1'b0;
                ld_l = 8'h00;
            end
        end
        chk_idle("ign.end");

        // reset mid-frame at count 4
        ld_l = 8'hFF; lv_l = 1'b1;
        tick();
        lv_l = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("abort.bit%0d", i), so_l, 1'b1);
            tick();
        end
        chk("abort.bit4", so_l, 1'b1);
        rst = 1'b1;
        tick();
        chk_idle("abort.rst");
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("abort.quiet_out%0d", i), so_l, 1'b0);
            chk($sformatf("abort.quiet_valid%0d", i), sv_l, 1'b0);
        end
        w = 8'h01; ld_l = w; lv_l = 1'b1;
        tick();
        lv_l = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("post.bit%0d", i), so_l, w[i]);
            chk($sformatf("post.fs%0d", i), fs_l, i == 0);
            tick();
        end
        chk_idle("post.end");

        // reset and accept on the same edge: word dropped
        rst = 1'b1; ld_l = 8'h55; lv_l = 1'b1;
        tick();
        chk_idle("rst_acc.rst");
        rst = 1'b0; lv_l = 1'b0;
        tick();
        chk_idle("rst_acc.after");
        tick();
        chk_idle("rst_acc.after2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
